// File: rtl/vector_accel_unit_if.sv
// Command/response bundle between a host controller and vector_accel_unit.
// The host drives the command and yumi; the unit drives status and read data.
interface vector_accel_unit_if #(
    parameter int els_p  = 10,
    parameter int vlen_p = 4,
    parameter int vdw_p  = 4
);
    localparam int AW = (els_p > 1) ? $clog2(els_p) : 1;

    logic [3:0]              op_i;
    logic [AW-1:0]           addrA_i;
    logic [AW-1:0]           addrB_i;
    logic [AW-1:0]           addrD_i;
    logic [vdw_p-1:0]        scalar_i;
    logic [vlen_p*vdw_p-1:0] w_data_i;
    logic                    v_i;
    logic                    ready_o;
    logic                    done_o;
    logic [vlen_p*vdw_p-1:0] r_data_o;
    logic                    v_o;
    logic                    yumi_i;

    modport master (
        output op_i, addrA_i, addrB_i, addrD_i, scalar_i, w_data_i, v_i, yumi_i,
        input  ready_o, done_o, r_data_o, v_o
    );

    modport slave (
        input  op_i, addrA_i, addrB_i, addrD_i, scalar_i, w_data_i, v_i, yumi_i,
        output ready_o, done_o, r_data_o, v_o
    );
endinterface

// File: rtl/vector_accel_unit.sv
// Small vector coprocessor: register file of els_p vectors, element-wise ALU
// ops and dot product executed on lanes_p lanes, single command in flight.
module vector_accel_unit #(
    parameter int els_p   = 10,
    parameter int vlen_p  = 4,
    parameter int vdw_p   = 4,
    parameter int lanes_p = 2
) (
    input logic clk_i,
    input logic reset_i,
    vector_accel_unit_if.slave bus
);
    localparam int AW  = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int GPV = vlen_p / lanes_p;
    localparam int CW  = (vlen_p > 1) ? $clog2(vlen_p) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE, RDATA} state_t;
    typedef logic [vlen_p-1:0][vdw_p-1:0] vec_t;

    state_t state, state_next;
    vec_t regs [els_p];
    vec_t opa, opb, acc, acc_next, row_vec, rd_vec, b_vec, r_data;
    logic is_dot;
    logic [1:0] alu_fn;
    logic [AW-1:0] base_b, dst, row_addr;
    logic [CW-1:0] grp, row;
    logic ready, accept, last_cycle, cmd_exec;
    logic row_ok, rd_ok, b_ok, wr_ok, dst_ok;
    logic [lanes_p-1:0][vdw_p-1:0] lane_a, lane_b, lane_r;
    logic [vdw_p-1:0] dot_sum;

    assign ready       = reset_i && (state == IDLE);
    assign accept      = ready && bus.v_i;
    assign cmd_exec    = (bus.op_i == 4'b1111) || (!bus.op_i[3] && bus.op_i[1:0] != 2'b11);
    assign last_cycle  = (grp == CW'(GPV - 1)) && (!is_dot || row == CW'(vlen_p - 1));

    assign rd_ok  = {1'b0, bus.addrA_i} < (AW+1)'(els_p);
    assign b_ok   = {1'b0, bus.addrB_i} < (AW+1)'(els_p);
    assign wr_ok  = {1'b0, bus.addrD_i} < (AW+1)'(els_p);
    assign dst_ok = {1'b0, dst} < (AW+1)'(els_p);
    assign rd_vec = rd_ok ? regs[bus.addrA_i] : '0;
    assign b_vec  = b_ok ? regs[bus.addrB_i] : '0;

    // Matrix rows are read live: nothing writes the register file until the final EXEC cycle
    assign row_addr = base_b + AW'(row);
    assign row_ok   = {1'b0, row_addr} < (AW+1)'(els_p);
    assign row_vec  = row_ok ? regs[row_addr] : '0;

    assign bus.ready_o  = ready;
    assign bus.v_o      = reset_i && (state == RDATA);
    assign bus.done_o   = reset_i && ((state == DONE) || (state == RDATA && bus.yumi_i));
    assign bus.r_data_o = r_data;

    // Route the current element group onto the lanes, compute, and merge into the buffer
    always_comb begin
        lane_a   = '0;
        lane_b   = '0;
        lane_r   = '0;
        dot_sum  = '0;
        acc_next = acc;
        for (int k = 0; k < vlen_p; k++) begin
            if (CW'(k / lanes_p) == grp) begin
                lane_a[k % lanes_p] = opa[k];
                lane_b[k % lanes_p] = is_dot ? row_vec[k] : opb[k];
            end
        end
        for (int l = 0; l < lanes_p; l++) begin
            if (is_dot) begin
                lane_r[l] = lane_a[l] * lane_b[l];
            end else begin
                case (alu_fn)
                    2'b00:   lane_r[l] = lane_a[l] + lane_b[l];
                    2'b01:   lane_r[l] = lane_a[l] - lane_b[l];
                    default: lane_r[l] = lane_a[l] * lane_b[l];
                endcase
            end
            dot_sum = dot_sum + lane_r[l];
        end
        for (int k = 0; k < vlen_p; k++) begin
            if (is_dot) begin
                if (CW'(k) == row) acc_next[k] = acc[k] + dot_sum;
            end else if (CW'(k / lanes_p) == grp) begin
                acc_next[k] = lane_r[k % lanes_p];
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.op_i == 4'b1000) state_next = RDATA;
                    else if (cmd_exec)       state_next = EXEC;
                    else                     state_next = DONE;
                end
            end
            EXEC:    if (last_cycle) state_next = DONE;
            DONE:    state_next = IDLE;
            RDATA:   if (bus.yumi_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state  <= IDLE;
            r_data <= '0;
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            grp    <= '0;
            row    <= '0;
            is_dot <= 1'b0;
            alu_fn <= '0;
            base_b <= '0;
            dst    <= '0;
            for (int i = 0; i < els_p; i++) regs[i] <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                opa    <= rd_vec;
                opb    <= bus.op_i[2] ? {vlen_p{bus.scalar_i}} : b_vec;
                acc    <= '0;
                grp    <= '0;
                row    <= '0;
                is_dot <= (bus.op_i == 4'b1111);
                alu_fn <= bus.op_i[1:0];
                base_b <= bus.addrB_i;
                dst    <= bus.addrD_i;
                if (bus.op_i == 4'b1000) r_data <= rd_vec;
                if (bus.op_i == 4'b1001 && wr_ok) regs[bus.addrD_i] <= bus.w_data_i;
            end else if (state == EXEC) begin
                acc <= acc_next;
                if (grp == CW'(GPV - 1)) begin
                    grp <= '0;
                    row <= row + CW'(1);
                end else begin
                    grp <= grp + CW'(1);
                end
                // Write-back happens once, so sources overlapping the destination stay intact
                if (last_cycle && dst_ok) regs[dst] <= acc_next;
            end
        end
    end
endmodule

// File: tb/tb_vector_accel_unit.sv
// Table-driven self-checking bench for vector_accel_unit with a read-data scoreboard.
module tb_vector_accel_unit;
    localparam int ELS = 10, VLEN = 4, VDW = 4, LANES = 2, AW = 4, DW = 16;
    localparam logic [3:0] OP_WRITE = 4'b1001, OP_READ = 4'b1000, OP_DOT = 4'b1111;
    localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_MUL = 4'b0010;
    localparam logic [3:0] OP_SADD = 4'b0100, OP_SSUB = 4'b0101, OP_SMUL = 4'b0110;
    localparam logic [3:0] OP_NOP = 4'b1010, OP_NOP2 = 4'b0011;

    typedef struct {
        logic [3:0]    op;
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [AW-1:0] d;
        logic [VDW-1:0] scalar;
        logic [DW-1:0] wdata;
        int            latency;
        logic [AW-1:0] rdAddr;
        logic [DW-1:0] expVal;
    } vecRec;

    logic clock = 1'b0;
    logic resetN = 1'b0;
    int testsRun = 0;
    int testsFailed = 0;
    logic [DW-1:0] scoreboard [$];
    vecRec vectors [20];

    vector_accel_unit_if #(.els_p(ELS), .vlen_p(VLEN), .vdw_p(VDW)) bus ();

    vector_accel_unit #(.els_p(ELS), .vlen_p(VLEN), .vdw_p(VDW), .lanes_p(LANES)) dut (
        .clk_i   (clock),
        .reset_i (resetN),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        testsRun++;
        if (actual !== required) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
        end
    endtask

    task automatic waitReady(input string name);
        int n = 0;
        while (bus.ready_o !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (bus.ready_o !== 1'b1) checkOutput({name, " ready timeout"}, 32'(bus.ready_o), 32'd1);
    endtask

    // Drive one command for a single accepting edge; returns at the negedge after acceptance
    task automatic issue(input logic [3:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [AW-1:0] d, input logic [VDW-1:0] s, input logic [DW-1:0] w);
        waitReady("issue");
        bus.op_i     = op;
        bus.addrA_i  = a;
        bus.addrB_i  = b;
        bus.addrD_i  = d;
        bus.scalar_i = s;
        bus.w_data_i = w;
        bus.v_i      = 1'b1;
        @(negedge clock);
        bus.v_i      = 1'b0;
    endtask

    task automatic applyStimulus(input vecRec r, input int idx);
        int lat = 1;
        issue(r.op, r.a, r.b, r.d, r.scalar, r.wdata);
        while (bus.done_o !== 1'b1 && lat < 50) begin
            @(negedge clock);
            lat++;
        end
        checkOutput($sformatf("rec%0d latency", idx), 32'(lat), 32'(r.latency));
        @(negedge clock);
        checkOutput($sformatf("rec%0d done/ready after", idx), 32'({bus.done_o, bus.ready_o}), 32'b01);
    endtask

    task automatic readAndCheck(input logic [AW-1:0] addr, input logic [DW-1:0] expVal, input string name);
        int n = 0;
        logic [DW-1:0] want;
        bus.yumi_i = 1'b1;
        scoreboard.push_back(expVal);
        issue(OP_READ, addr, '0, '0, '0, '0);
        while (bus.v_o !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        checkOutput({name, " v_o"}, 32'(bus.v_o), 32'd1);
        want = scoreboard.pop_front();
        checkOutput({name, " data"}, 32'(bus.r_data_o), 32'(want));
        checkOutput({name, " done"}, 32'(bus.done_o), 32'd1);
        @(negedge clock);
        bus.yumi_i = 1'b0;
        checkOutput({name, " v_o drop"}, 32'(bus.v_o), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] held;
        bit sawDone;

        vectors[0]  = '{OP_WRITE, 4'd0, 4'd0, 4'd0, 4'h0, 16'h1111, 1, 4'd0, 16'h1111};
        vectors[1]  = '{OP_WRITE, 4'd0, 4'd0, 4'd1, 4'h0, 16'h4321, 1, 4'd1, 16'h4321};
        vectors[2]  = '{OP_WRITE, 4'd0, 4'd0, 4'd2, 4'h0, 16'h2222, 1, 4'd2, 16'h2222};
        vectors[3]  = '{OP_WRITE, 4'd0, 4'd0, 4'd3, 4'h0, 16'h1007, 1, 4'd3, 16'h1007};
        vectors[4]  = '{OP_WRITE, 4'd0, 4'd0, 4'd4, 4'h0, 16'h2306, 1, 4'd4, 16'h2306};
        vectors[5]  = '{OP_DOT,   4'd0, 4'd1, 4'd5, 4'h0, 16'h0000, 9, 4'd5, 16'hB88A};
        vectors[6]  = '{OP_ADD,   4'd1, 4'd2, 4'd7, 4'h0, 16'h0000, 3, 4'd7, 16'h6543};
        vectors[7]  = '{OP_SUB,   4'd2, 4'd1, 4'd7, 4'h0, 16'h0000, 3, 4'd7, 16'hEF01};
        vectors[8]  = '{OP_MUL,   4'd1, 4'd2, 4'd7, 4'h0, 16'h0000, 3, 4'd7, 16'h8642};
        vectors[9]  = '{OP_SADD,  4'd1, 4'd0, 4'd7, 4'hF, 16'h0000, 3, 4'd7, 16'h3210};
        vectors[10] = '{OP_SMUL,  4'd3, 4'd0, 4'd7, 4'h2, 16'h0000, 3, 4'd7, 16'h200E};
        vectors[11] = '{OP_SSUB,  4'd1, 4'd0, 4'd7, 4'h2, 16'h0000, 3, 4'd7, 16'h210F};
        vectors[12] = '{OP_WRITE, 4'd0, 4'd0, 4'd12, 4'h0, 16'hFFFF, 1, 4'd12, 16'h0000};
        vectors[13] = '{OP_NOP,   4'd0, 4'd0, 4'd7, 4'h0, 16'h0000, 1, 4'd7, 16'h210F};
        vectors[14] = '{OP_NOP2,  4'd1, 4'd2, 4'd7, 4'h0, 16'h0000, 1, 4'd7, 16'h210F};
        vectors[15] = '{OP_WRITE, 4'd0, 4'd0, 4'd9, 4'h0, 16'h1234, 1, 4'd9, 16'h1234};
        vectors[16] = '{OP_DOT,   4'd0, 4'd9, 4'd8, 4'h0, 16'h0000, 9, 4'd8, 16'h000A};
        vectors[17] = '{OP_DOT,   4'd0, 4'd15, 4'd8, 4'h0, 16'h0000, 9, 4'd8, 16'h8A40};
        vectors[18] = '{OP_ADD,   4'd1, 4'd1, 4'd1, 4'h0, 16'h0000, 3, 4'd1, 16'h8642};
        vectors[19] = '{OP_DOT,   4'd0, 4'd0, 4'd0, 4'h0, 16'h0000, 9, 4'd0, 16'h8844};

        bus.op_i = '0; bus.addrA_i = '0; bus.addrB_i = '0; bus.addrD_i = '0;
        bus.scalar_i = '0; bus.w_data_i = '0; bus.v_i = 1'b0; bus.yumi_i = 1'b0;

        // Reset state
        repeat (3) @(negedge clock);
        checkOutput("reset ready_o", 32'(bus.ready_o), 32'd0);
        checkOutput("reset done_o", 32'(bus.done_o), 32'd0);
        checkOutput("reset v_o", 32'(bus.v_o), 32'd0);
        checkOutput("reset r_data_o", 32'(bus.r_data_o), 32'd0);
        resetN = 1'b1;
        #1;
        checkOutput("post-reset ready_o", 32'(bus.ready_o), 32'd1);
        readAndCheck(4'd6, 16'h0000, "cleared reg6");

        for (int i = 0; i < 20; i++) begin
            applyStimulus(vectors[i], i);
            readAndCheck(vectors[i].rdAddr, vectors[i].expVal, $sformatf("rec%0d read", i));
        end

        // Read stalled by the consumer; a command offered while busy must be ignored
        bus.yumi_i = 1'b0;
        scoreboard.push_back(16'h2222);
        held = 16'h2222;
        issue(OP_READ, 4'd2, '0, '0, '0, '0);
        for (int c = 0; c < 5; c++) begin
            checkOutput($sformatf("stall%0d v/ready/done", c),
                        32'({bus.v_o, bus.ready_o, bus.done_o}), 32'b100);
            checkOutput($sformatf("stall%0d data", c), 32'(bus.r_data_o), 32'(held));
            if (c == 1) begin
                bus.op_i = OP_WRITE; bus.addrD_i = 4'd2; bus.w_data_i = 16'hFFFF; bus.v_i = 1'b1;
            end
            if (c == 2) bus.v_i = 1'b0;
            @(negedge clock);
        end
        bus.yumi_i = 1'b1;
        #1;
        checkOutput("stall release done_o", 32'(bus.done_o), 32'd1);
        checkOutput("stall release data", 32'(bus.r_data_o), 32'(scoreboard.pop_front()));
        @(negedge clock);
        bus.yumi_i = 1'b0;
        checkOutput("stall after v/ready", 32'({bus.v_o, bus.ready_o}), 32'b01);
        checkOutput("stall data retained", 32'(bus.r_data_o), 32'(held));
        readAndCheck(4'd2, 16'h2222, "ignored write reg2");

        // Reset in the middle of a DOT: aborted, nothing written, back to idle
        issue(OP_DOT, 4'd0, 4'd1, 4'd6, '0, '0);
        repeat (3) @(negedge clock);
        resetN = 1'b0;
        @(negedge clock);
        checkOutput("mid-reset ready/done/v", 32'({bus.ready_o, bus.done_o, bus.v_o}), 32'b000);
        resetN = 1'b1;
        #1;
        checkOutput("abort ready_o", 32'(bus.ready_o), 32'd1);
        sawDone = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (bus.done_o === 1'b1) sawDone = 1'b1;
        end
        checkOutput("abort no done_o", 32'(sawDone), 32'd0);
        readAndCheck(4'd6, 16'h0000, "aborted dest reg6");
        readAndCheck(4'd1, 16'h0000, "reset cleared reg1");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/vector_accel_unit.md
Name: vector_accel_unit

Overview:
- Small vector coprocessor holding `els_p` vectors of `vlen_p` elements, each `vdw_p` bits wide, in an internal register file.
- Accepts one command at a time over a valid/ready interface: vector write, vector read, element-wise ALU ops (vector-vector or vector-scalar), and a dot-product / partial matrix-vector multiply.
- Element arithmetic is executed on `lanes_p` parallel lanes.
- Sits as a leaf accelerator beneath a host controller.

Parameters:
- els_p, 10: number of vectors in the register file.
- vlen_p, 4: elements per vector.
- vdw_p, 4: bits per element.
- lanes_p, 2: parallel element lanes; `vlen_p` must be a multiple of `lanes_p`.
- Derived: AW = clog2(els_p), min 1.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset.
- op_i  in  4  command opcode.
- addrA_i  in  AW  source A address (read/ALU/dot).
- addrB_i  in  AW  source B address (ALU) / matrix base row (dot).
- addrD_i  in  AW  destination address.
- scalar_i  in  vdw_p  scalar operand for scalar ALU ops.
- w_data_i  in  vlen_p*vdw_p  write data; element k occupies bits [k*vdw_p +: vdw_p].
- v_i  in  1  command valid.
- ready_o  out  1  unit idle, can accept a command.
- done_o  out  1  one-cycle completion pulse.
- r_data_o  out  vlen_p*vdw_p  read data, same packing as `w_data_i`.
- v_o  out  1  read data valid.
- yumi_i  in  1  consumer accepts read data.

Behaviour:
- Interface: one clock, `clk_i`; `reset_i` is synchronous and active-low (reset when `reset_i`=0 at a rising edge).
- Reset values: state IDLE, ready_o=0 while in reset and 1 after, done_o=0, v_o=0, r_data_o=0, register file cleared to 0.
- Reset mid-operation: abort the command, discard pending writes, return to IDLE.
- Acceptance: a command is taken on a rising edge with v_i=1 & ready_o=1, and all operands are latched then.
  - ready_o=1 only in IDLE.
  - v_i is ignored while busy.
- Opcodes:
  - 1001 WRITE: `reg[addrD_i] <= w_data_i`. Commit and done_o one cycle after acceptance.
  - 1000 READ: next cycle `r_data_o <= reg[addrA_i]` and v_o=1.
    - v_o and r_data_o hold until yumi_i=1 while v_o=1.
    - In that handshake cycle done_o=1; v_o drops the following cycle.
    - r_data_o keeps its value until the next READ.
  - 00ff vector-vector ALU: `D[k] = A[k] op B[k]`.
  - 01ff vector-scalar ALU: `D[k] = A[k] op scalar_i`.
  - ff field: 00 add, 01 sub (A minus B), 10 mul; results keep the low `vdw_p` bits (wrap modulo 2^vdw_p, unsigned).
  - 1111 DOT: `D[j] = sum over k of A[k]*reg[addrB_i+j][k]`, mod 2^vdw_p, for j = 0..vlen_p-1. Row address arithmetic wraps modulo 2^AW; rows with address >= els_p read as zero.
  - All other opcodes (0011, 0111, 1010-1110): no-op, done_o one cycle after acceptance.
- Timing:
  - ALU: EXEC state processes `lanes_p` elements per cycle for vlen_p/lanes_p cycles, then one DONE cycle with done_o=1.
  - DOT: vlen_p*vlen_p/lanes_p multiply-accumulate cycles, then DONE.
- Write-back: ALU and DOT results go to an internal buffer and are written to reg[addrD_i] on the final EXEC cycle. Overlapping source/destination addresses therefore always use pre-command source values.
- FSM: IDLE -> (WRITE/NOP) DONE; IDLE -> (ALU/DOT) EXEC -> DONE; IDLE -> (READ) RDATA -> (yumi_i) IDLE. DONE -> IDLE after exactly one cycle.
- done_o is high exactly one cycle per command. Next command may be accepted the cycle after done_o.
- Addresses >= els_p: writes ignored, reads return zero.

Test Plan:
- Write reg0=0x1111, reg1=0x4321, reg2=0x2222, reg3=0x1007, reg4=0x2306 -> each gives one done_o pulse one cycle after acceptance.
- DOT D=5, A=0, B=1, then READ 5 with yumi_i=1 -> r_data_o=0xB88A (16'b1011_1000_1000_1010), v_o and done_o asserted.
- ALU add D=7, A=1, B=2, READ 7 -> 0x6543. Sub A=2, B=1 -> 0xEF01. Mul A=1, B=2 -> 0x8642.
- Scalar add (op 0100) A=1, scalar=0xF -> 0x3210 (wraparound). Scalar mul (op 0110) A=3, scalar=2 -> 0x200E.
- READ with yumi_i held 0 for 5 cycles -> v_o and r_data_o stable, ready_o=0, a second v_i ignored; raise yumi_i -> done_o pulse, then ready_o=1.
- Drive reset_i=0 during a DOT EXEC -> next cycle ready_o=1 (after reset_i=1), done_o=0, destination not written (reads 0).
